interval_timer_master: RTL

- Autonomous Avalon-MM initiator that programs and services the 16-bit-data interval timer peripheral with no CPU involved.
- A simple start/stop host interface drives it. It writes the period and control registers, waits for the timer irq, clears the status register, and reports each timeout as a one-cycle tick.
- Sits beside the timer slave in the UART subsystem and replaces software timer handling for fixed-rate baud/timeout generation.

---
 rtl/interval_timer_pkg.sv | 66 ++++++
 rtl/interval_timer_master_if.sv | 21 ++
 rtl/interval_timer_master.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/interval_timer_pkg.sv
// Shared register map, control encoding, FSM states and bus command type for interval_timer_master.
// The snapshot states exist only when INTERVAL_TIMER_SNAP_EN is defined.
package interval_timer_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;

  localparam logic [ADDR_W-1:0] TMR_STATUS   = 3'd0;
  localparam logic [ADDR_W-1:0] TMR_CONTROL  = 3'd1;
  localparam logic [ADDR_W-1:0] TMR_PERIOD_L = 3'd2;
  localparam logic [ADDR_W-1:0] TMR_PERIOD_H = 3'd3;
  localparam logic [ADDR_W-1:0] TMR_SNAP_L   = 3'd4;
  localparam logic [ADDR_W-1:0] TMR_SNAP_H   = 3'd5;

  localparam int unsigned CTRL_ITO_BIT   = 0;
  localparam int unsigned CTRL_CONT_BIT  = 1;
  localparam int unsigned CTRL_START_BIT = 2;
  localparam int unsigned CTRL_STOP_BIT  = 3;

  localparam logic [DATA_W-1:0] CTRL_START_CONT =
    DATA_W'((1 << CTRL_ITO_BIT) | (1 << CTRL_CONT_BIT) | (1 << CTRL_START_BIT));
  localparam logic [DATA_W-1:0] CTRL_START_ONESHOT =
    DATA_W'((1 << CTRL_ITO_BIT) | (1 << CTRL_START_BIT));
  localparam logic [DATA_W-1:0] CTRL_STOP = DATA_W'(1 << CTRL_STOP_BIT);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_GAP,
    ST_WR_CTRL,
    ST_RUN,
    ST_CLR_ST,
    ST_SETTLE,
    ST_STOPW
`ifdef INTERVAL_TIMER_SNAP_EN
    ,
    ST_SNAP_WR,
    ST_SNAP_RH,
    ST_SNAP_RL,
    ST_SNAP_WAIT
`endif
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
  } avm_cmd_t;

  localparam avm_cmd_t AVM_IDLE = '{address: TMR_STATUS, chipselect: 1'b0,
                                    write_n: 1'b1, writedata: '0};

  // Single-cycle write strobe to one timer register.
  function automatic avm_cmd_t wr_cmd(input logic [ADDR_W-1:0] addr,
                                      input logic [DATA_W-1:0] data);
    avm_cmd_t c;
    c.address    = addr;
    c.chipselect = 1'b1;
    c.write_n    = 1'b0;
    c.writedata  = data;
    return c;
  endfunction

endpackage

// File: rtl/interval_timer_master_if.sv
// Avalon-MM link between interval_timer_master and the interval timer slave, plus the timer irq.
interface interval_timer_master_if;
  import interval_timer_pkg::*;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              timer_irq;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, timer_irq
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, timer_irq
  );
endinterface

// File: rtl/interval_timer_master.sv
// Autonomous Avalon-MM initiator that programs the interval timer, services its irq and emits ticks.
// Optional counter snapshot path is built when INTERVAL_TIMER_SNAP_EN is defined.
module interval_timer_master
  import interval_timer_pkg::*;
#(
  parameter int unsigned TICK_W       = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [31:0]                period_i,
  input  logic                       continuous_i,
  output logic                       busy_o,
  output logic                       tick_o,
  output logic [TICK_W-1:0]          tick_count_o,
  interval_timer_master_if.master    avm,
  input  logic                       snap_req_i,
  output logic                       snap_valid_o,
  output logic [31:0]                snap_value_o
);

  state_e      state_q, state_d, run_next_c;
  avm_cmd_t    cmd_q, cmd_d;
  logic [31:0] period_q;
  logic        cont_q;
  logic        stop_pend_q;
  logic        stop_req_c;
  logic [31:0] period_clamp_c;

  assign stop_req_c     = stop_pend_q | stop_i;
  assign period_clamp_c = (period_i == 32'd0) ? 32'd1 : period_i;

`ifdef INTERVAL_TIMER_SNAP_EN
  localparam int unsigned SNAP_CNT_W = $clog2(READ_LATENCY + 3);

  logic                  snap_pend_q;
  logic                  snap_req_c;
  logic [SNAP_CNT_W-1:0] snap_cnt_q;
  logic [DATA_W-1:0]     snap_hi_q;
  logic                  snap_rd_c;
  logic                  snap_done_c;
  state_e                snap_exit_c;

  assign snap_req_c  = snap_pend_q | snap_req_i;
  assign snap_rd_c   = (state_q == ST_SNAP_RH) || (state_q == ST_SNAP_RL) ||
                       (state_q == ST_SNAP_WAIT);
  assign snap_done_c = (snap_cnt_q == SNAP_CNT_W'(READ_LATENCY + 1));
  // A timeout that lands during the snapshot is serviced straight away.
  assign snap_exit_c = avm.timer_irq ? ST_CLR_ST : (stop_req_c ? ST_STOPW : ST_RUN);
`endif

  // Next-state and next bus command; the command is decoded from the next state so it is registered.
  always_comb begin
    state_d    = state_q;
    cmd_d      = AVM_IDLE;
    run_next_c = ST_RUN;

    if (avm.timer_irq)   run_next_c = ST_CLR_ST;
    else if (stop_req_c) run_next_c = ST_STOPW;
`ifdef INTERVAL_TIMER_SNAP_EN
    else if (snap_req_c) run_next_c = ST_SNAP_WR;
`endif

    case (state_q)
      ST_IDLE:      if (start_i) state_d = ST_WR_PL;
      ST_WR_PL:     state_d = ST_WR_PH;
      ST_WR_PH:     state_d = ST_GAP;
      ST_GAP:       state_d = ST_WR_CTRL;
      ST_WR_CTRL:   state_d = stop_req_c ? ST_STOPW : ST_RUN;
      ST_RUN:       state_d = run_next_c;
      ST_CLR_ST:    state_d = ST_SETTLE;
      ST_SETTLE:    state_d = stop_req_c ? ST_STOPW : (cont_q ? ST_RUN : ST_IDLE);
      ST_STOPW:     state_d = ST_IDLE;
`ifdef INTERVAL_TIMER_SNAP_EN
      ST_SNAP_WR:   state_d = ST_SNAP_RH;
      ST_SNAP_RH:   state_d = ST_SNAP_RL;
      ST_SNAP_RL:   state_d = snap_done_c ? snap_exit_c : ST_SNAP_WAIT;
      ST_SNAP_WAIT: state_d = snap_done_c ? snap_exit_c : ST_SNAP_WAIT;
`endif
      default:      state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_WR_PL:     cmd_d = wr_cmd(TMR_PERIOD_L, period_clamp_c[15:0]);
      ST_WR_PH:     cmd_d = wr_cmd(TMR_PERIOD_H, period_q[31:16]);
      ST_WR_CTRL:   cmd_d = wr_cmd(TMR_CONTROL, cont_q ? CTRL_START_CONT : CTRL_START_ONESHOT);
      ST_CLR_ST:    cmd_d = wr_cmd(TMR_STATUS, '0);
      ST_STOPW:     cmd_d = wr_cmd(TMR_CONTROL, CTRL_STOP);
`ifdef INTERVAL_TIMER_SNAP_EN
      ST_SNAP_WR:   cmd_d = wr_cmd(TMR_SNAP_L, '0);
      ST_SNAP_RH:   cmd_d.address = TMR_SNAP_H;
      ST_SNAP_RL:   cmd_d.address = TMR_SNAP_L;
`endif
      default:      cmd_d = AVM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cmd_q        <= AVM_IDLE;
      period_q     <= '0;
      cont_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      busy_o       <= 1'b0;
      tick_o       <= 1'b0;
      tick_count_o <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      busy_o  <= (state_d != ST_IDLE);
      tick_o  <= (state_d == ST_CLR_ST);

      if ((state_q == ST_IDLE) && start_i) begin
        period_q     <= period_clamp_c;
        cont_q       <= continuous_i;
        tick_count_o <= '0;
      end else if (state_d == ST_CLR_ST) begin
        tick_count_o <= tick_count_o + TICK_W'(1);
      end

      // Stop requests wait until the current bus sequence or irq service completes.
      if ((state_d == ST_STOPW) || (state_d == ST_IDLE))
        stop_pend_q <= 1'b0;
      else if (stop_i && (state_q != ST_IDLE))
        stop_pend_q <= 1'b1;
    end
  end

  assign avm.avm_address    = cmd_q.address;
  assign avm.avm_chipselect = cmd_q.chipselect;
  assign avm.avm_write_n    = cmd_q.write_n;
  assign avm.avm_writedata  = cmd_q.writedata;

`ifdef INTERVAL_TIMER_SNAP_EN
  // Counts cycles from the high-half address cycle; each half is sampled READ_LATENCY cycles later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_pend_q  <= 1'b0;
      snap_cnt_q   <= '0;
      snap_hi_q    <= '0;
      snap_valid_o <= 1'b0;
      snap_value_o <= '0;
    end else begin
      if (state_d == ST_SNAP_WR) snap_pend_q <= 1'b0;
      else if (snap_req_i)       snap_pend_q <= 1'b1;

      snap_cnt_q   <= snap_rd_c ? snap_cnt_q + SNAP_CNT_W'(1) : '0;
      snap_valid_o <= 1'b0;

      if (snap_rd_c && (snap_cnt_q == SNAP_CNT_W'(READ_LATENCY)))
        snap_hi_q <= avm.avm_readdata;
      if (snap_rd_c && snap_done_c) begin
        snap_value_o <= {snap_hi_q, avm.avm_readdata};
        snap_valid_o <= 1'b1;
      end
    end
  end
`else
  logic unused_snap;
  assign unused_snap  = ^{snap_req_i, avm.avm_readdata, 32'(READ_LATENCY)};
  assign snap_valid_o = 1'b0;
  assign snap_value_o = '0;
`endif

endmodule
